axi4_stream_pkt_arbiter: RTL and testbench
==========================================

# axi4_stream_pkt_arbiter

Packet-level round-robin arbiter that shares one AXI4-Stream datapath, such as a width converter or FIFO, between several AXI4-Stream sources. A channel keeps the output until the handshake of its `tlast` beat, so packets never interleave. The data path is a combinational mux, and arbitration costs one idle cycle between packets. The block sits upstream of the shared stream resource.

## Interface
Parameters:
- `CHANNELS_AMOUNT`, default 4: number of requesting input streams; must be at least 2.
- `TDATA_WIDTH`, default 32: tdata width of all streams in bits; must be a multiple of 8.
- `TID_WIDTH`, default 1: tid width of all streams.
- `TDEST_WIDTH`, default 1: tdest width of all streams.
- `TUSER_WIDTH`, default 1: tuser width of all streams.
- `TID_FROM_CHANNEL`, default 0:
  - 0: pass the source tid through unchanged.
  - 1: drive `pkt_o.tid` with the granted channel index, zero-extended. This requires `TID_WIDTH >= $clog2(CHANNELS_AMOUNT)`.

Ports:
- `clk_i`  input  1: the single clock; all logic is on its rising edge.
- `rst_i`  input  1: synchronous, active-high reset.
- `pkt_i[CHANNELS_AMOUNT]`  axi4_stream_if.slave  array: input streams; channel index = array index.
- `pkt_o`  axi4_stream_if.master: shared output stream.
- `grant_o`  output  CHANNELS_AMOUNT: one-hot mask of the granted channel; all zeros when idle.
- `busy_o`  output  1: high while in BUSY.

## Operation
State machine, two states:
- IDLE:
  - `pkt_o.tvalid` = 0 and every `pkt_i[k].tready` = 0.
  - If any `pkt_i[k].tvalid` = 1, select the winner with round-robin from `last_ptr`, register it in `grant_idx`, and go to BUSY on the next edge.
  - Otherwise stay in IDLE.
- BUSY:
  - `pkt_o` = `pkt_i[grant_idx]` for tvalid, tdata, tkeep, tstrb, tlast, tdest and tuser; tid is driven per `TID_FROM_CHANNEL`.
  - `pkt_i[grant_idx].tready` = `pkt_o.tready`; all other `pkt_i[k].tready` = 0.
  - On an output handshake with `tlast` = 1: set `last_ptr` <= `grant_idx`, go to IDLE, and clear `grant_o`.

Round-robin rule:
- The search order is `last_ptr+1`, `last_ptr+2`, … and wraps modulo `CHANNELS_AMOUNT`. The first channel with tvalid = 1 wins.
- `last_ptr` resets to `CHANNELS_AMOUNT-1`, so after reset channel 0 has the highest priority.
- A channel that keeps requesting waits at most `CHANNELS_AMOUNT-1` packets.

Decisions and width rules:
- `grant_idx` and `last_ptr` are `$clog2(CHANNELS_AMOUNT)` bits wide. The wrap is explicit, so non-power-of-two counts never select a non-existent index.
- The grant decision reads only tvalid. A source may not retract tvalid once asserted (AXI rule), so the winner is guaranteed to present data in BUSY.
- tvalid low during BUSY is legal. The grant holds indefinitely until `tlast` is handshaken; there is no timeout.
- The block never modifies tlast, tkeep or tstrb, and never inserts or drops beats.
- `grant_o` is registered from `grant_idx` and is valid during BUSY. `busy_o` = (state == BUSY).

## Timing
Reset:
- While `rst_i` = 1 and on the first cycle after it: state = IDLE, `last_ptr` = `CHANNELS_AMOUNT-1`, `grant_o` = 0, `busy_o` = 0.
- Outputs during that time: `pkt_o.tvalid` = 0, all `pkt_i[k].tready` = 0. All `pkt_o` payload fields read 0 in IDLE.

Latency:
- Data path: 0 cycles (combinational) in BUSY.
- Arbitration: a request seen in IDLE in cycle N gives BUSY and a possible first handshake in cycle N+1.

Throughput and packet boundaries:
- Maximum rate is one beat per cycle inside a packet.
- Every packet boundary costs exactly one IDLE cycle, even when the same channel is re-granted.
- A single-beat packet costs 2 cycles: IDLE, then BUSY with the tlast handshake.

Handshake and backpressure:
- `pkt_o.tready` low stalls the granted source only. Payload must stay stable because it passes straight through from the source.

Boundary cases:
- tlast handshake while other requests are pending: the next winner is computed in the following IDLE cycle from the updated `last_ptr`.
- All channels requesting: strict rotation 0,1,2,…,`CHANNELS_AMOUNT-1`,0.
- Reset asserted mid-packet: the grant drops immediately at the edge and `pkt_o.tvalid` falls without tlast. Upstream and downstream must reset together; no recovery is attempted.

## Test plan
- Reset with all inputs valid: during reset, `pkt_o.tvalid` = 0, `grant_o` = 0, no tready. First grant goes to channel 0; `grant_o` = 4'b0001 one cycle after reset release.
- Four channels, each sending a 3-beat packet continuously: output channel order is 0,1,2,3,0,…; no interleaving; exactly one tvalid = 0 cycle at every boundary; 4 packets in 16 cycles.
- Only channel 2 requests, sending back-to-back single-beat packets: beats arrive on alternate cycles; `grant_o` = 4'b0100 every BUSY cycle.
- Channel 1 is granted and `pkt_o.tready` toggles randomly: payload matches channel 1 beat-for-beat, other channels' tready stays 0, and channel 3 (requesting) waits until channel 1's tlast handshake.
- `CHANNELS_AMOUNT` = 3, `TID_FROM_CHANNEL` = 1, `last_ptr` = 2: channel 0 wins the next request (wrap check), and `pkt_o.tid` = 0, 1, 2 for packets from channels 0, 1, 2.
- `rst_i` pulsed for one cycle during beat 2 of a 5-beat packet: the next cycle is IDLE with `grant_o` = 0 and `pkt_o.tvalid` = 0; re-arbitration then restarts from channel 0.

Source files
------------

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle shared by the packet arbiter and its neighbours.
// Master drives payload and tvalid, slave drives tready.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-level round-robin arbiter: one source owns the shared stream until
// its tlast beat handshakes, then one IDLE cycle re-arbitrates.
module axi4_stream_pkt_arbiter #(
    parameter int CHANNELS_AMOUNT  = 4,
    parameter int TDATA_WIDTH      = 32,
    parameter int TID_WIDTH        = 1,
    parameter int TDEST_WIDTH      = 1,
    parameter int TUSER_WIDTH      = 1,
    parameter bit TID_FROM_CHANNEL = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    axi4_stream_if.slave               pkt_i [CHANNELS_AMOUNT],
    axi4_stream_if.master              pkt_o,
    output logic [CHANNELS_AMOUNT-1:0] grant_o,
    output logic                       busy_o
);
    localparam int IDX_W  = $clog2(CHANNELS_AMOUNT);
    localparam int SUM_W  = IDX_W + 1;
    localparam int KEEP_W = TDATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]           last_ptr_q, last_ptr_d;
    logic [CHANNELS_AMOUNT-1:0] grant_q, grant_d;

    logic [CHANNELS_AMOUNT-1:0] tvalid_w;
    logic [CHANNELS_AMOUNT-1:0] tlast_w;
    logic [TDATA_WIDTH-1:0]     tdata_w [CHANNELS_AMOUNT];
    logic [KEEP_W-1:0]          tkeep_w [CHANNELS_AMOUNT];
    logic [KEEP_W-1:0]          tstrb_w [CHANNELS_AMOUNT];
    logic [TID_WIDTH-1:0]       tid_w   [CHANNELS_AMOUNT];
    logic [TDEST_WIDTH-1:0]     tdest_w [CHANNELS_AMOUNT];
    logic [TUSER_WIDTH-1:0]     tuser_w [CHANNELS_AMOUNT];

    logic                       busy;
    logic                       last_hs;
    logic                       rr_found;
    logic [IDX_W-1:0]           rr_winner;
    logic [SUM_W-1:0]           rr_sum;

    assign busy = (state_q == ST_BUSY);

    // Flatten the interface array so the mux can use a run-time index.
    for (genvar k = 0; k < CHANNELS_AMOUNT; k++) begin : g_ch
        assign tvalid_w[k] = pkt_i[k].tvalid;
        assign tlast_w[k]  = pkt_i[k].tlast;
        assign tdata_w[k]  = pkt_i[k].tdata;
        assign tkeep_w[k]  = pkt_i[k].tkeep;
        assign tstrb_w[k]  = pkt_i[k].tstrb;
        assign tid_w[k]    = pkt_i[k].tid;
        assign tdest_w[k]  = pkt_i[k].tdest;
        assign tuser_w[k]  = pkt_i[k].tuser;
        assign pkt_i[k].tready = busy && (grant_idx_q == IDX_W'(k)) && pkt_o.tready;
    end

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pkt_o.tvalid = 1'b0;
        pkt_o.tdata  = '0;
        pkt_o.tkeep  = '0;
        pkt_o.tstrb  = '0;
        pkt_o.tlast  = 1'b0;
        pkt_o.tid    = '0;
        pkt_o.tdest  = '0;
        pkt_o.tuser  = '0;
        if (busy) begin
            pkt_o.tvalid = tvalid_w[grant_idx_q];
            pkt_o.tdata  = tdata_w[grant_idx_q];
            pkt_o.tkeep  = tkeep_w[grant_idx_q];
            pkt_o.tstrb  = tstrb_w[grant_idx_q];
            pkt_o.tlast  = tlast_w[grant_idx_q];
            pkt_o.tid    = TID_FROM_CHANNEL ? TID_WIDTH'(grant_idx_q) : tid_w[grant_idx_q];
            pkt_o.tdest  = tdest_w[grant_idx_q];
            pkt_o.tuser  = tuser_w[grant_idx_q];
        end
    end

    assign last_hs = busy && pkt_o.tvalid && pkt_o.tready && pkt_o.tlast;

    // Search last_ptr+1, last_ptr+2, ... with an explicit wrap so that
    // non-power-of-two channel counts never pick a missing index.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_ptr_q;
        rr_sum    = '0;
        for (int i = 1; i <= CHANNELS_AMOUNT; i++) begin
            rr_sum = {1'b0, last_ptr_q} + SUM_W'(i);
            if (rr_sum >= SUM_W'(CHANNELS_AMOUNT)) begin
                rr_sum = rr_sum - SUM_W'(CHANNELS_AMOUNT);
            end
            if (!rr_found && tvalid_w[rr_sum[IDX_W-1:0]]) begin
                rr_found  = 1'b1;
                rr_winner = rr_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_ptr_d  = last_ptr_q;
        grant_d     = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    state_d     = ST_BUSY;
                    grant_idx_d = rr_winner;
                    grant_d     = CHANNELS_AMOUNT'(1) << rr_winner;
                end
            end
            ST_BUSY: begin
                if (last_hs) begin
                    state_d    = ST_IDLE;
                    last_ptr_d = grant_idx_q;
                    grant_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            last_ptr_q  <= IDX_W'(CHANNELS_AMOUNT - 1);
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_ptr_q  <= last_ptr_d;
            grant_q     <= grant_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy;

endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Directed bench for the packet arbiter: a 4-channel instance with scripted
// packet sources, and a 3-channel instance that drives tid from the channel.
module tb_axi4_stream_pkt_arbiter;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- 4-channel instance ----------------
    axi4_stream_if src_a [4] ();
    axi4_stream_if out_a ();
    logic [3:0]  grant_a;
    logic        busy_a;
    logic        out_tready;
    logic [3:0]  a_tvalid;
    logic [3:0]  a_tlast;
    logic [3:0]  a_tready;
    logic [31:0] a_tdata [4];

    int pkts_left [4];
    int plen      [4];
    int beat      [4];
    int pkt       [4];

    for (genvar k = 0; k < 4; k++) begin : g_src_a
        assign src_a[k].tvalid = a_tvalid[k];
        assign src_a[k].tdata  = a_tdata[k];
        assign src_a[k].tkeep  = 4'hF;
        assign src_a[k].tstrb  = 4'hF;
        assign src_a[k].tlast  = a_tlast[k];
        assign src_a[k].tid    = 1'b0;
        assign src_a[k].tdest  = 1'b0;
        assign src_a[k].tuser  = 1'b0;
        assign a_tready[k]     = src_a[k].tready;
    end
    assign out_a.tready = out_tready;

    axi4_stream_pkt_arbiter dut_a (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .pkt_i   (src_a),
        .pkt_o   (out_a),
        .grant_o (grant_a),
        .busy_o  (busy_a)
    );

    // ---------------- 3-channel instance, tid from channel ----------------
    axi4_stream_if #(.TDATA_WIDTH(8), .TID_WIDTH(2)) src_b [3] ();
    axi4_stream_if #(.TDATA_WIDTH(8), .TID_WIDTH(2)) out_b ();
    logic [2:0] grant_b;
    logic       busy_b;

    for (genvar k = 0; k < 3; k++) begin : g_src_b
        assign src_b[k].tvalid = 1'b1;
        assign src_b[k].tdata  = 8'hA0 + 8'(k);
        assign src_b[k].tkeep  = 1'b1;
        assign src_b[k].tstrb  = 1'b1;
        assign src_b[k].tlast  = 1'b1;
        assign src_b[k].tid    = 2'b11;
        assign src_b[k].tdest  = 1'b0;
        assign src_b[k].tuser  = 1'b0;
    end
    assign out_b.tready = 1'b1;

    axi4_stream_pkt_arbiter #(
        .CHANNELS_AMOUNT  (3),
        .TDATA_WIDTH      (8),
        .TID_WIDTH        (2),
        .TID_FROM_CHANNEL (1'b1)
    ) dut_b (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .pkt_i   (src_b),
        .pkt_o   (out_b),
        .grant_o (grant_b),
        .busy_o  (busy_b)
    );

    // ---------------- source model and observation helpers ----------------
    task automatic drive_src();
        for (int k = 0; k < 4; k++) begin
            a_tvalid[k] = (pkts_left[k] != 0);
            a_tdata[k]  = {8'(k), 8'(pkt[k]), 16'(beat[k])};
            a_tlast[k]  = (beat[k] == plen[k] - 1);
        end
    endtask

    task automatic set_src(input int k, input int n, input int len);
        pkts_left[k] = n;
        plen[k]      = len;
        beat[k]      = 0;
        pkt[k]       = 0;
        drive_src();
    endtask

    // Starts and ends at a falling edge; sources advance on the handshakes
    // that were visible just before the rising edge.
    task automatic cycle();
        logic [3:0] hs;
        hs = a_tvalid & a_tready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k] === 1'b1) begin
                beat[k]++;
                if (beat[k] == plen[k]) begin
                    beat[k] = 0;
                    pkt[k]++;
                    pkts_left[k]--;
                end
            end
        end
        drive_src();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        for (int k = 0; k < 4; k++) set_src(k, 0, 1);
        cycle();
        cycle();
        rst_i = 1'b0;
    endtask

    function automatic logic [38:0] obs_a();
        return {busy_a, grant_a, out_a.tvalid, out_a.tlast, out_a.tdata};
    endfunction

    function automatic logic [38:0] exp_beat(input int ch, input int p, input int b, input logic last);
        return {1'b1, 4'(1 << ch), 1'b1, last, 8'(ch), 8'(p), 16'(b)};
    endfunction

    function automatic logic [15:0] obs_b();
        return {busy_b, grant_b, out_b.tvalid, out_b.tlast, out_b.tid, out_b.tdata};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [38:0] e;
        rst_i      = 1'b1;
        out_tready = 1'b1;
        for (int k = 0; k < 4; k++) set_src(k, 1, 2);
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (obs_a() !== 39'd0 || a_tready !== 4'b0000) begin
                $display("FAIL reset_hold: got obs=%h tready=%b expected obs=0 tready=0000", obs_a(), a_tready);
                failures++;
            end
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (obs_a() !== 39'd0) begin
            $display("FAIL reset_first_idle: got %h expected 0", obs_a());
            failures++;
        end
        cycle();
        e = exp_beat(0, 0, 0, 1'b0);
        checks++;
        if (obs_a() !== e || a_tready !== 4'b0001) begin
            $display("FAIL reset_first_grant: got obs=%h tready=%b expected obs=%h tready=0001", obs_a(), a_tready, e);
            failures++;
        end
    endtask

    task automatic test_rotation();
        logic [38:0] e;
        do_reset();
        out_tready = 1'b1;
        for (int k = 0; k < 4; k++) set_src(k, 2, 3);
        for (int ch = 0; ch < 4; ch++) begin
            checks++;
            if (obs_a() !== 39'd0) begin
                $display("FAIL rotation_gap ch%0d: got %h expected 0", ch, obs_a());
                failures++;
            end
            cycle();
            for (int b = 0; b < 3; b++) begin
                e = exp_beat(ch, 0, b, b == 2);
                checks++;
                if (obs_a() !== e) begin
                    $display("FAIL rotation_beat ch%0d b%0d: got %h expected %h", ch, b, obs_a(), e);
                    failures++;
                end
                cycle();
            end
        end
        checks++;
        if (obs_a() !== 39'd0) begin
            $display("FAIL rotation_wrap_gap: got %h expected 0", obs_a());
            failures++;
        end
        cycle();
        e = exp_beat(0, 1, 0, 1'b0);
        checks++;
        if (obs_a() !== e) begin
            $display("FAIL rotation_wrap: got %h expected %h", obs_a(), e);
            failures++;
        end
    endtask

    task automatic test_single_beat_ch2();
        logic [38:0] e;
        do_reset();
        out_tready = 1'b1;
        set_src(2, 3, 1);
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (obs_a() !== 39'd0) begin
                $display("FAIL single_idle p%0d: got %h expected 0", p, obs_a());
                failures++;
            end
            cycle();
            e = exp_beat(2, p, 0, 1'b1);
            checks++;
            if (obs_a() !== e || a_tready !== 4'b0100) begin
                $display("FAIL single_beat p%0d: got obs=%h tready=%b expected obs=%h tready=0100", p, obs_a(), a_tready, e);
                failures++;
            end
            cycle();
        end
        checks++;
        if (obs_a() !== 39'd0) begin
            $display("FAIL single_drained: got %h expected 0", obs_a());
            failures++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic [38:0] e;
        logic [3:0]  et;
        int          eb;
        pat = 16'b0110_1001_1101_0010;
        do_reset();
        out_tready = 1'b0;
        set_src(1, 1, 4);
        cycle();
        set_src(3, 1, 1);
        eb = 0;
        for (int i = 0; i < 24 && eb < 4; i++) begin
            out_tready = pat[i % 16];
            #1;
            e  = exp_beat(1, 0, eb, eb == 3);
            et = out_tready ? 4'b0010 : 4'b0000;
            checks++;
            if (obs_a() !== e || a_tready !== et) begin
                $display("FAIL backpressure i%0d: got obs=%h tready=%b expected obs=%h tready=%b", i, obs_a(), a_tready, e, et);
                failures++;
            end
            if (out_tready) eb++;
            cycle();
        end
        checks++;
        if (eb != 4) begin
            $display("FAIL backpressure_timeout: got %0d beats expected 4", eb);
            failures++;
        end
        out_tready = 1'b1;
        checks++;
        if (obs_a() !== 39'd0) begin
            $display("FAIL backpressure_gap: got %h expected 0", obs_a());
            failures++;
        end
        cycle();
        e = exp_beat(3, 0, 0, 1'b1);
        checks++;
        if (obs_a() !== e) begin
            $display("FAIL backpressure_ch3: got %h expected %h", obs_a(), e);
            failures++;
        end
    endtask

    task automatic test_tid_wrap();
        int          seq [4];
        logic [15:0] e;
        seq = '{0, 1, 2, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_b() !== 16'd0) begin
                $display("FAIL tid_idle i%0d: got %h expected 0", i, obs_b());
                failures++;
            end
            cycle();
            e = {1'b1, 3'(1 << seq[i]), 1'b1, 1'b1, 2'(seq[i]), 8'hA0 + 8'(seq[i])};
            checks++;
            if (obs_b() !== e) begin
                $display("FAIL tid_grant i%0d: got %h expected %h", i, obs_b(), e);
                failures++;
            end
            cycle();
        end
    endtask

    task automatic test_mid_reset();
        logic [38:0] e;
        do_reset();
        out_tready = 1'b1;
        set_src(2, 1, 5);
        cycle();
        e = exp_beat(2, 0, 0, 1'b0);
        checks++;
        if (obs_a() !== e) begin
            $display("FAIL midrst_beat1: got %h expected %h", obs_a(), e);
            failures++;
        end
        cycle();
        e = exp_beat(2, 0, 1, 1'b0);
        checks++;
        if (obs_a() !== e) begin
            $display("FAIL midrst_beat2: got %h expected %h", obs_a(), e);
            failures++;
        end
        set_src(0, 1, 1);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        checks++;
        if (obs_a() !== 39'd0 || a_tready !== 4'b0000) begin
            $display("FAIL midrst_idle: got obs=%h tready=%b expected obs=0 tready=0000", obs_a(), a_tready);
            failures++;
        end
        cycle();
        e = exp_beat(0, 0, 0, 1'b1);
        checks++;
        if (obs_a() !== e) begin
            $display("FAIL midrst_regrant: got %h expected %h", obs_a(), e);
            failures++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pkts_left[k] = 0;
            plen[k]      = 1;
            beat[k]      = 0;
            pkt[k]       = 0;
        end
        drive_src();
        test_reset();
        test_rotation();
        test_single_beat_ch2();
        test_backpressure();
        test_tid_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
